// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB writeback stage.
//   DATA_W, REG_AW : default datapath and register-address widths
//   load_type_e    : load-width encodings carried alongside each instruction
package mem_wb_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;

   typedef enum logic [2:0] {
      LT_LW  = 3'd0,
      LT_LB  = 3'd1,
      LT_LBU = 3'd2,
      LT_LH  = 3'd3,
      LT_LHU = 3'd4
   } load_type_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load-data extraction for little-endian byte lanes.
//   rdata      : raw memory word
//   offset     : low two address bits of the load
//   load_type  : load width/signedness (unknown codes behave as lw)
//   data       : extracted, extended load value
//   misaligned : halfword on an odd address, or word not on a word boundary
module mem_wb_stage_load_align #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        offset,
   input  logic [2:0]        load_type,
   output logic [DATA_W-1:0] data,
   output logic              misaligned
);
   import mem_wb_stage_pkg::*;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = rdata[{offset, 3'b000} +: 8];
      half_sel   = rdata[{offset[1], 4'b0000} +: 16];
      data       = rdata;
      misaligned = 1'b0;
      case (load_type)
         LT_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LT_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
         LT_LH: begin
            data       = {{(DATA_W-16){half_sel[15]}}, half_sel};
            misaligned = offset[0];
         end
         LT_LHU: begin
            data       = {{(DATA_W-16){1'b0}}, half_sel};
            misaligned = offset[0];
         end
         default: misaligned = (offset != 2'b00);
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: owns the MEM/WB slot, aligns load data, drives the
// register-file write port.
//   clk, reset (async, active-low)
//   in_*          : EX/MEM instruction fields, captured into the slot
//   ReadData      : memory read data, arrives one cycle after in_*
//   stall, flush  : hold the slot / discard the instruction being captured
//   wb_*          : register-file write port
//   fwd_valid     : slot result usable for forwarding (ignores stall)
//   misalign      : sticky misaligned-load flag
//   retired       : retired-instruction counter
module mem_wb_stage #(
   parameter int unsigned DATA_W = mem_wb_stage_pkg::DATA_W,
   parameter int unsigned REG_AW = mem_wb_stage_pkg::REG_AW,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_RegWrite,
   input  logic              in_MemToReg,
   input  logic              in_Link,
   input  logic [2:0]        in_LoadType,
   input  logic [REG_AW-1:0] in_WriteReg,
   input  logic [DATA_W-1:0] in_ALUResult,
   input  logic [DATA_W-1:0] in_PCPlus4,
   input  logic [DATA_W-1:0] ReadData,
   input  logic              stall,
   input  logic              flush,
   output logic              wb_RegWrite,
   output logic [REG_AW-1:0] wb_WriteReg,
   output logic [DATA_W-1:0] wb_WriteData,
   output logic              fwd_valid,
   output logic              misalign,
   output logic [CNT_W-1:0]  retired
);
   import mem_wb_stage_pkg::*;

   logic              slot_valid_q;
   logic              slot_regwrite_q;
   logic              slot_memtoreg_q;
   logic              slot_link_q;
   logic [2:0]        slot_loadtype_q;
   logic [REG_AW-1:0] slot_writereg_q;
   logic [DATA_W-1:0] slot_aluresult_q;
   logic [DATA_W-1:0] slot_pcplus4_q;
   logic              hold_valid_q;
   logic [DATA_W-1:0] hold_data_q;
   logic              misalign_q;
   logic [CNT_W-1:0]  retired_q;

   logic [DATA_W-1:0] read_data;
   logic [DATA_W-1:0] load_data;
   logic              load_misaligned;
   logic              misaligned_load;
   logic              writes_reg;

   // ReadData is only valid for one cycle; during a stall the captured copy stands in.
   assign read_data = hold_valid_q ? hold_data_q : ReadData;

   mem_wb_stage_load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .rdata      (read_data),
      .offset     (slot_aluresult_q[1:0]),
      .load_type  (slot_loadtype_q),
      .data       (load_data),
      .misaligned (load_misaligned)
   );

   // Alignment only matters for actual loads, not ALU results that happen to be odd.
   assign misaligned_load = slot_valid_q & slot_memtoreg_q & load_misaligned;
   assign writes_reg      = slot_valid_q & slot_regwrite_q & (slot_writereg_q != '0)
                            & ~misaligned_load;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_valid_q     <= 1'b0;
         slot_regwrite_q  <= 1'b0;
         slot_memtoreg_q  <= 1'b0;
         slot_link_q      <= 1'b0;
         slot_loadtype_q  <= '0;
         slot_writereg_q  <= '0;
         slot_aluresult_q <= '0;
         slot_pcplus4_q   <= '0;
         hold_valid_q     <= 1'b0;
         hold_data_q      <= '0;
         misalign_q       <= 1'b0;
         retired_q        <= '0;
      end else begin
         // flush wins over stall for the valid bit
         if (flush) begin
            slot_valid_q <= 1'b0;
         end else if (!stall) begin
            slot_valid_q <= in_valid;
         end
         if (!stall) begin
            slot_regwrite_q  <= in_RegWrite;
            slot_memtoreg_q  <= in_MemToReg;
            slot_link_q      <= in_Link;
            slot_loadtype_q  <= in_LoadType;
            slot_writereg_q  <= in_WriteReg;
            slot_aluresult_q <= in_ALUResult;
            slot_pcplus4_q   <= in_PCPlus4;
         end

         if (flush || !stall) begin
            hold_valid_q <= 1'b0;
         end else if (!hold_valid_q) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= ReadData;
         end

         if (misaligned_load) begin
            misalign_q <= 1'b1;
         end
         if (slot_valid_q && !stall) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      wb_WriteData = slot_aluresult_q;
      if (slot_link_q) begin
         wb_WriteData = slot_pcplus4_q;
      end else if (slot_memtoreg_q) begin
         wb_WriteData = load_data;
      end
   end

   assign wb_WriteReg = slot_writereg_q;
   assign wb_RegWrite = writes_reg & ~stall;
   assign fwd_valid   = writes_reg;
   assign misalign    = misalign_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_RegWrite, in_MemToReg, in_Link;
   logic [2:0]  in_LoadType;
   logic [4:0]  in_WriteReg;
   logic [31:0] in_ALUResult, in_PCPlus4, ReadData;
   logic        stall, flush;
   logic        wb_RegWrite;
   logic [4:0]  wb_WriteReg;
   logic [31:0] wb_WriteData;
   logic        fwd_valid, misalign;
   logic [31:0] retired;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_ret = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_RegWrite  (in_RegWrite),
      .in_MemToReg  (in_MemToReg),
      .in_Link      (in_Link),
      .in_LoadType  (in_LoadType),
      .in_WriteReg  (in_WriteReg),
      .in_ALUResult (in_ALUResult),
      .in_PCPlus4   (in_PCPlus4),
      .ReadData     (ReadData),
      .stall        (stall),
      .flush        (flush),
      .wb_RegWrite  (wb_RegWrite),
      .wb_WriteReg  (wb_WriteReg),
      .wb_WriteData (wb_WriteData),
      .fwd_valid    (fwd_valid),
      .misalign     (misalign),
      .retired      (retired)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                        input logic [2:0] lt, input logic [4:0] wr, input logic [31:0] alu,
                        input logic [31:0] pc4);
      in_valid = v; in_RegWrite = rw; in_MemToReg = m2r; in_Link = lnk;
      in_LoadType = lt; in_WriteReg = wr; in_ALUResult = alu; in_PCPlus4 = pc4;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %0b want 0", wb_RegWrite); end
      n_cmp++; if (fwd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fwd: got %0b want 0", fwd_valid); end
      n_cmp++; if (wb_WriteReg !== 5'd0) begin n_bad++; $display("FAIL rst_wr: got %0d want 0", wb_WriteReg); end
      n_cmp++; if (wb_WriteData !== 32'h0) begin n_bad++; $display("FAIL rst_wd: got %h want 0", wb_WriteData); end
      n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL rst_mis: got %0b want 0", misalign); end
      n_cmp++; if (retired !== 32'd0) begin n_bad++; $display("FAIL rst_ret: got %0d want 0", retired); end
   endtask

   task automatic test_lw();
      drive(1, 1, 1, 0, 3'd0, 5'd8, 32'h10, 32'h0);
      tick();
      in_valid = 0; ReadData = 32'hDEADBEEF; #1;
      n_cmp++; if (wb_RegWrite !== 1'b1) begin n_bad++; $display("FAIL lw_we: got %0b want 1", wb_RegWrite); end
      n_cmp++; if (wb_WriteReg !== 5'd8) begin n_bad++; $display("FAIL lw_wr: got %0d want 8", wb_WriteReg); end
      n_cmp++; if (wb_WriteData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_wd: got %h want deadbeef", wb_WriteData); end
      n_cmp++; if (fwd_valid !== 1'b1) begin n_bad++; $display("FAIL lw_fwd: got %0b want 1", fwd_valid); end
      tick(); exp_ret++;
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL lw_ret: got %0d want %0d", retired, exp_ret); end
      n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL lw_empty: got %0b want 0", wb_RegWrite); end
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 1, 0, 3'd1, 5'd1, 32'h13, 32'h0);          // lb
      tick();
      ReadData = 32'h80FF7F01;
      drive(1, 1, 1, 0, 3'd2, 5'd2, 32'h13, 32'h0); #1;     // lbu
      n_cmp++; if (wb_WriteData !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb: got %h want ffffff80", wb_WriteData); end
      n_cmp++; if (wb_RegWrite !== 1'b1 || wb_WriteReg !== 5'd1) begin n_bad++; $display("FAIL lb_we: got %0b/%0d want 1/1", wb_RegWrite, wb_WriteReg); end
      tick();
      drive(1, 1, 1, 0, 3'd3, 5'd3, 32'h12, 32'h0); #1;     // lh
      n_cmp++; if (wb_WriteData !== 32'h00000080) begin n_bad++; $display("FAIL lbu: got %h want 00000080", wb_WriteData); end
      tick();
      drive(1, 1, 1, 0, 3'd4, 5'd4, 32'h10, 32'h0); #1;     // lhu
      n_cmp++; if (wb_WriteData !== 32'hFFFF80FF) begin n_bad++; $display("FAIL lh: got %h want ffff80ff", wb_WriteData); end
      tick();
      in_valid = 0; #1;
      n_cmp++; if (wb_WriteData !== 32'h00007F01) begin n_bad++; $display("FAIL lhu: got %h want 00007f01", wb_WriteData); end
      n_cmp++; if (wb_RegWrite !== 1'b1 || wb_WriteReg !== 5'd4) begin n_bad++; $display("FAIL lhu_we: got %0b/%0d want 1/4", wb_RegWrite, wb_WriteReg); end
      tick(); exp_ret += 4;
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL b2b_ret: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_misalign();
      drive(1, 1, 1, 0, 3'd0, 5'd5, 32'h12, 32'h0);          // lw at 0x12
      tick();
      in_valid = 0; ReadData = 32'h11112222; #1;
      n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL mis_we: got %0b want 0", wb_RegWrite); end
      n_cmp++; if (fwd_valid !== 1'b0) begin n_bad++; $display("FAIL mis_fwd: got %0b want 0", fwd_valid); end
      tick(); exp_ret++;
      n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL mis_flag: got %0b want 1", misalign); end
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL mis_ret: got %0d want %0d", retired, exp_ret); end
      drive(1, 1, 1, 0, 3'd4, 5'd6, 32'h13, 32'h0);          // lhu at odd address
      tick();
      drive(1, 1, 1, 0, 3'd0, 5'd6, 32'h14, 32'h0); #1;      // aligned lw next
      n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL mis_lhu_we: got %0b want 0", wb_RegWrite); end
      tick();
      drive(1, 1, 0, 0, 3'd0, 5'd7, 32'h13, 32'h0); #1;      // ALU op, odd result
      n_cmp++; if (wb_RegWrite !== 1'b1 || wb_WriteData !== 32'h11112222) begin n_bad++; $display("FAIL mis_after_lw: got %0b/%h want 1/11112222", wb_RegWrite, wb_WriteData); end
      tick();
      in_valid = 0; #1;
      n_cmp++; if (wb_RegWrite !== 1'b1 || wb_WriteData !== 32'h13) begin n_bad++; $display("FAIL alu_odd: got %0b/%h want 1/00000013", wb_RegWrite, wb_WriteData); end
      tick(); exp_ret += 3;
      n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL mis_sticky: got %0b want 1", misalign); end
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL mis_ret2: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_stall();
      drive(1, 1, 1, 0, 3'd0, 5'd9, 32'h20, 32'h0);
      tick();
      in_valid = 0; ReadData = 32'h12345678; stall = 1; #1;
      n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL stl_we0: got %0b want 0", wb_RegWrite); end
      n_cmp++; if (fwd_valid !== 1'b1) begin n_bad++; $display("FAIL stl_fwd: got %0b want 1", fwd_valid); end
      tick();
      ReadData = 32'h55555555; #1;
      n_cmp++; if (wb_RegWrite !== 1'b0 || wb_WriteData !== 32'h12345678) begin n_bad++; $display("FAIL stl_hold1: got %0b/%h want 0/12345678", wb_RegWrite, wb_WriteData); end
      tick(); #1;
      n_cmp++; if (wb_RegWrite !== 1'b0 || wb_WriteData !== 32'h12345678) begin n_bad++; $display("FAIL stl_hold2: got %0b/%h want 0/12345678", wb_RegWrite, wb_WriteData); end
      tick();
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL stl_ret_hold: got %0d want %0d", retired, exp_ret); end
      stall = 0; #1;
      n_cmp++; if (wb_RegWrite !== 1'b1 || wb_WriteData !== 32'h12345678 || wb_WriteReg !== 5'd9) begin n_bad++; $display("FAIL stl_release: got %0b/%h/%0d want 1/12345678/9", wb_RegWrite, wb_WriteData, wb_WriteReg); end
      tick(); exp_ret++;
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL stl_ret: got %0d want %0d", retired, exp_ret); end
      n_cmp++; if (wb_RegWrite !== 1'b0) begin n_bad++; $display("FAIL stl_single: got %0b want 0", wb_RegWrite); end
   endtask

   task automatic test_flush();
      drive(1, 1, 1, 0, 3'd0, 5'd10, 32'h30, 32'h0);
      flush = 1;
      tick();
      flush = 0; in_valid = 0; #1;
      n_cmp++; if (wb_RegWrite !== 1'b0 || fwd_valid !== 1'b0) begin n_bad++; $display("FAIL fl_we: got %0b/%0b want 0/0", wb_RegWrite, fwd_valid); end
      tick();
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL fl_ret: got %0d want %0d", retired, exp_ret); end
      drive(1, 1, 0, 0, 3'd0, 5'd11, 32'h77, 32'h0);
      tick();
      drive(1, 1, 0, 0, 3'd0, 5'd12, 32'h88, 32'h0);
      stall = 1; flush = 1;
      tick();
      stall = 0; flush = 0; in_valid = 0; #1;
      n_cmp++; if (wb_RegWrite !== 1'b0 || fwd_valid !== 1'b0) begin n_bad++; $display("FAIL flst_we: got %0b/%0b want 0/0", wb_RegWrite, fwd_valid); end
      tick();
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL flst_ret: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_zero_reg();
      drive(1, 1, 0, 0, 3'd0, 5'd0, 32'h99, 32'h0);
      tick();
      in_valid = 0; #1;
      n_cmp++; if (wb_RegWrite !== 1'b0 || fwd_valid !== 1'b0) begin n_bad++; $display("FAIL r0_we: got %0b/%0b want 0/0", wb_RegWrite, fwd_valid); end
      tick(); exp_ret++;
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL r0_ret: got %0d want %0d", retired, exp_ret); end
   endtask

   task automatic test_reset_mid();
      drive(1, 1, 1, 0, 3'd0, 5'd12, 32'h40, 32'h0);
      tick();
      in_valid = 0; reset = 0; #1;
      n_cmp++; if (wb_RegWrite !== 1'b0 || fwd_valid !== 1'b0) begin n_bad++; $display("FAIL mr_we: got %0b/%0b want 0/0", wb_RegWrite, fwd_valid); end
      n_cmp++; if (wb_WriteReg !== 5'd0 || wb_WriteData !== 32'h0) begin n_bad++; $display("FAIL mr_port: got %0d/%h want 0/0", wb_WriteReg, wb_WriteData); end
      n_cmp++; if (retired !== 32'd0 || misalign !== 1'b0) begin n_bad++; $display("FAIL mr_state: got %0d/%0b want 0/0", retired, misalign); end
      exp_ret = 0;
      drive(1, 1, 0, 1, 3'd0, 5'd31, 32'h999, 32'h404);     // jal
      tick();
      reset = 1;
      tick();
      in_valid = 0; #1;
      n_cmp++; if (wb_RegWrite !== 1'b1 || wb_WriteReg !== 5'd31 || wb_WriteData !== 32'h404) begin n_bad++; $display("FAIL jal: got %0b/%0d/%h want 1/31/00000404", wb_RegWrite, wb_WriteReg, wb_WriteData); end
      tick(); exp_ret++;
      n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL jal_ret: got %0d want %0d", retired, exp_ret); end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset = 0; stall = 0; flush = 0; ReadData = 32'h0;
      drive(0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
      tick();
      tick();
      test_reset();
      reset = 1;
      tick();
      test_lw();
      test_back_to_back();
      test_misalign();
      test_stall();
      test_flush();
      test_zero_reg();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Writeback stage directly downstream of the data-memory stage; owns the MEM/WB pipeline register.
- The memory stage returns ReadData one clock after it sees the address and MemRead. This block therefore registers the accompanying control, address and link data so they line up with ReadData.
- Extracts byte/halfword load data, selects the writeback source and drives the register-file write port.
- Also provides a forwarding tap, a misalignment flag and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-file address width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; asserted when 0
- in_valid  in  1  EX/MEM slot holds a real instruction; presented in the same cycle the memory stage sees the address
- in_RegWrite  in  1  instruction writes a register
- in_MemToReg  in  1  writeback source is load data
- in_Link  in  1  writeback source is in_PCPlus4 (jal/jalr)
- in_LoadType  in  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; other codes treated as lw
- in_WriteReg  in  REG_AW  destination register
- in_ALUResult  in  DATA_W  memory address or ALU result
- in_PCPlus4  in  DATA_W  link value
- ReadData  in  DATA_W  memory-stage read data, valid one cycle after in_*
- stall  in  1  hold MEM/WB contents
- flush  in  1  discard the instruction being captured this edge
- wb_RegWrite  out  1  register-file write enable
- wb_WriteReg  out  REG_AW  register-file write address
- wb_WriteData  out  DATA_W  register-file write data
- fwd_valid  out  1  wb_WriteData/wb_WriteReg usable for forwarding
- misalign  out  1  sticky misaligned-load flag
- retired  out  CNT_W  count of instructions retired

Behaviour:
- Reset: all slot registers, hold_valid, misalign and retired go to 0. wb_RegWrite=0, fwd_valid=0, wb_WriteReg=0, wb_WriteData=0. Reset mid-operation drops the in-flight slot immediately; no write occurs.
- Capture, when not stalled: on each edge the slot takes {in_valid & ~flush, in_*}. Latency is in_* at cycle N to register-file write at the end of cycle N+1.
- flush has priority over stall. When flush=1 the slot valid clears on that edge even if stall=1, and hold_valid clears.
- Stall: when stall=1 and flush=0, the slot holds.
  - On the first stalled edge, the current ReadData is copied to hold_data and hold_valid is set to 1.
  - While hold_valid=1, hold_data replaces ReadData.
  - hold_valid clears on the first edge with stall=0.
- Load extraction, using byte offset a=slot_ALUResult[1:0] and little-endian lanes:
  - lb/lbu: byte a, sign- or zero-extended.
  - lh/lhu: halfword a[1], sign- or zero-extended.
  - lw: full word.
- Source select, in priority order: Link gives PCPlus4; otherwise MemToReg gives extracted data; otherwise ALUResult.
- Misalignment: a load is misaligned when it is lh/lhu with a[0]=1, or lw with a!=0.
  - A misaligned load suppresses its write and sets misalign.
  - misalign is sticky; only reset clears it.
- wb_RegWrite = slot_valid & slot_RegWrite & (slot_WriteReg!=0) & ~stall & ~misaligned_load.
- fwd_valid = slot_valid & slot_RegWrite & (slot_WriteReg!=0) & ~misaligned_load. It is independent of stall.
- wb_WriteReg and wb_WriteData are combinational from the slot and are always driven. The outputs from the previous bullet are only meaningful when the corresponding enable is 1.
- retired increments by 1 on each edge where slot_valid=1 and stall=0, including non-writing instructions and misaligned loads. It wraps modulo 2^CNT_W.

Decomposition:
- Shared package holds:
  - LoadType encodings: LT_LW, LT_LB, LT_LBU, LT_LH, LT_LHU.
  - DATA_W and REG_AW constants.
- One sub-module is natural: load_align, a combinational unit taking (ReadData, offset, LoadType) and producing (data, misaligned).

Test Plan:
- lw, in_ALUResult=0x10, in_WriteReg=8, ReadData=0xDEADBEEF the next cycle -> wb_RegWrite=1, wb_WriteReg=8, wb_WriteData=0xDEADBEEF; retired=1.
- lb at 0x13 then lbu at 0x13, word 0x80FF7F01 -> 0xFFFFFF80 and 0x00000080. lh at 0x12 -> 0xFFFF80FF. lhu at 0x10 -> 0x00007F01.
- lw at 0x12 -> no write, misalign=1, retired increments. Misalign stays 1 across later valid loads until reset=0.
- Load in the slot, stall=1 for 3 cycles while ReadData changes to 0x55555555 after the first stalled edge -> wb_RegWrite=0 throughout. On release, a single write of the original data. retired increments once.
- flush=1 with in_valid=1 (and with stall=1 simultaneously) -> slot empty, no write, retired unchanged. Writes to $0 -> wb_RegWrite=0, fwd_valid=0.
- reset asserted mid-load and jal with in_PCPlus4=0x404 -> all outputs 0 during reset. After release, jal writes 0x404 to reg 31.
